tvbg_button_conditioner: RTL and testbench

//  Upstream front end of tv_b_gone: turns the raw, bouncy, asynchronous user button into clean control.
//  2-FF synchroniser, debounce, short/long press classification, busy-aware single-slot start queue.

---
 rtl/tvbg_pkg.sv | 21 ++
 rtl/tvbg_btn_debounce.sv | 74 +++++++
 rtl/tvbg_button_conditioner.sv | 185 ++++++++++++++++++
 tb/tb_tvbg_button_conditioner.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tvbg_pkg.sv
// -----------------------------------------------------------------------------
// tvbg_pkg
// Shared types and default timing constants for the tv_b_gone button front end.
//   btn_state_t          : press-classifier state (IDLE / HELD / LONG), 2 bits,
//                          encoding is visible on state_out for debug/trace.
//   DEF_DEBOUNCE_CYCLES  : 10 ms at the 8 MHz core clock.
//   DEF_LONG_CYCLES      : 1 s at the 8 MHz core clock.
// Optional feature macro used by the users of this package: TVBG_BTN_LONGPRESS_EN
// -----------------------------------------------------------------------------
package tvbg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      LONG = 2'd2
   } btn_state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 80_000;
   localparam int unsigned DEF_LONG_CYCLES     = 8_000_000;

endpackage

// File: rtl/tvbg_btn_debounce.sv
// -----------------------------------------------------------------------------
// tvbg_btn_debounce
// Two-flop synchroniser plus debounce filter for the raw user button.
// The raw pin is normalised so that 1 always means "pressed".
// Ports:
//   clock_in   in   core clock, all logic on posedge
//   reset_in   in   synchronous active-high reset (level returns to released)
//   button_in  in   raw asynchronous button pin
//   pressed    out  debounced level, 1 = pressed (registered)
//   rise       out  pressed goes 0->1 at the coming clock edge (combinational)
//   fall       out  pressed goes 1->0 at the coming clock edge (combinational)
// Latency from a raw edge to the pressed change is DEBOUNCE_CYCLES + 2 cycles.
// -----------------------------------------------------------------------------
module tvbg_btn_debounce
   import tvbg_pkg::*;
#(
   parameter bit          ACTIVE_LOW      = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clock_in,
   input  logic reset_in,
   input  logic button_in,
   output logic pressed,
   output logic rise,
   output logic fall
);

   localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);

   logic          raw_norm;
   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;
   logic          flip;

   assign raw_norm = ACTIVE_LOW ? ~button_in : button_in;

   // Flip once the synchronised level has disagreed with the accepted level
   // for a full run (counter saturated) and still disagrees now.
   always_comb begin
      flip = 1'b0;
      if ((sync2 != pressed) && (cnt == CNT_MAX)) begin
         flip = 1'b1;
      end else begin
         flip = 1'b0;
      end
   end

   assign rise = flip & ~pressed;
   assign fall = flip &  pressed;

   // Synchroniser, disagreement-run counter and accepted level.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         pressed <= 1'b0;
         cnt     <= {CW{1'b0}};
      end else begin
         sync1 <= raw_norm;
         sync2 <= sync1;
         if (sync2 == pressed) begin
            cnt <= {CW{1'b0}};
         end else if (flip) begin
            pressed <= ~pressed;
            cnt     <= {CW{1'b0}};
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/tvbg_button_conditioner.sv
// -----------------------------------------------------------------------------
// tvbg_button_conditioner
// Front end of tv_b_gone: raw bouncy button -> clean start pulse / loop mode.
// Debounced press is classified by a small FSM; start requests pass through a
// one-deep queue that holds a request while tv_b_gone reports busy.
// Optional feature macro: TVBG_BTN_LONGPRESS_EN
//   defined   : start on short-press release, long press toggles loop mode
//   undefined : start on press, no long-press detection, loop mode tied 0
// Ports:
//   clock_in          in   core clock (8 MHz), all logic on posedge
//   reset_in          in   synchronous active-high reset
//   button_in         in   raw asynchronous button pin
//   busy_in           in   tv_b_gone busy; start withheld while high
//   start_out         out  1-cycle start pulse
//   loop_forever_out  out  loop-mode level
//   pressed_out       out  debounced button level, 1 = pressed
//   pending_out       out  a start is queued waiting for busy_in low
//   state_out         out  classifier state encoding (IDLE=0/HELD=1/LONG=2)
// -----------------------------------------------------------------------------
module tvbg_button_conditioner
   import tvbg_pkg::*;
#(
   parameter bit          ACTIVE_LOW      = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
   input  logic       clock_in,
   input  logic       reset_in,
   input  logic       button_in,
   input  logic       busy_in,
   output logic       start_out,
   output logic       loop_forever_out,
   output logic       pressed_out,
   output logic       pending_out,
   output logic [1:0] state_out
);

   logic       pressed;
   logic       rise;
   logic       fall;
   btn_state_t state;
   btn_state_t state_next;
   logic       req;
   logic       req_next;
   logic       start;
   logic       pending;

   tvbg_btn_debounce #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clock_in  (clock_in),
      .reset_in  (reset_in),
      .button_in (button_in),
      .pressed   (pressed),
      .rise      (rise),
      .fall      (fall)
   );

`ifdef TVBG_BTN_LONGPRESS_EN
   localparam int unsigned   HW        = $clog2(LONG_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

   logic [HW-1:0] hold;
   logic [HW-1:0] hold_next;
   logic          loop;
   logic          loop_next;

   // State register with hold counter, loop level and registered start request.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state <= IDLE;
         hold  <= {HW{1'b0}};
         loop  <= 1'b0;
         req   <= 1'b0;
      end else begin
         state <= state_next;
         hold  <= hold_next;
         loop  <= loop_next;
         req   <= req_next;
      end
   end

   // Next-state: release wins over reaching the long threshold on the same edge.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (rise) state_next = HELD; else state_next = IDLE;
         HELD: begin
            if (fall)                   state_next = IDLE;
            else if (hold == HOLD_LAST) state_next = LONG;
            else                        state_next = HELD;
         end
         LONG:    if (fall) state_next = IDLE; else state_next = LONG;
         default: state_next = IDLE;
      endcase
   end

   // Outputs: short-press start request, loop toggle, saturating hold count.
   always_comb begin
      hold_next = hold;
      loop_next = loop;
      req_next  = 1'b0;
      case (state)
         IDLE: begin
            if (rise) hold_next = {HW{1'b0}}; else hold_next = hold;
         end
         HELD: begin
            if (fall)                   req_next  = 1'b1;
            else if (hold == HOLD_LAST) loop_next = ~loop;
            else                        loop_next = loop;
            if (hold != HOLD_MAX) hold_next = hold + HW'(1); else hold_next = hold;
         end
         LONG:    hold_next = hold;
         default: hold_next = {HW{1'b0}};
      endcase
   end

   assign loop_forever_out = loop;
`else
   // State register and registered start request.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state <= IDLE;
         req   <= 1'b0;
      end else begin
         state <= state_next;
         req   <= req_next;
      end
   end

   // Next-state: track the debounced level only.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (rise) state_next = HELD; else state_next = IDLE;
         HELD:    if (fall) state_next = IDLE; else state_next = HELD;
         default: state_next = IDLE;
      endcase
   end

   // Outputs: start request on the press itself, no release wait.
   always_comb begin
      req_next = 1'b0;
      case (state)
         IDLE:    if (rise) req_next = 1'b1; else req_next = 1'b0;
         default: req_next = 1'b0;
      endcase
   end

   assign loop_forever_out = 1'b0;
`endif

   // One-slot start queue. A start is never issued right after another one,
   // so a request arriving as a pulse leaves is parked instead.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         start   <= 1'b0;
         pending <= 1'b0;
      end else begin
         if (pending && !busy_in && !start) begin
            start   <= 1'b1;
            pending <= 1'b0;
         end else if (req && !pending) begin
            if (busy_in || start) begin
               start   <= 1'b0;
               pending <= 1'b1;
            end else begin
               start   <= 1'b1;
               pending <= 1'b0;
            end
         end else begin
            start   <= 1'b0;
            pending <= pending;
         end
      end
   end

   assign start_out   = start;
   assign pending_out = pending;
   assign pressed_out = pressed;
   assign state_out   = state;

endmodule

// File: tb/tb_tvbg_button_conditioner.sv
module tb_tvbg_button_conditioner;
   import tvbg_pkg::*;

   localparam int D = 4;
   localparam int L = 20;

   logic       clock_in = 1'b0;
   logic       reset_in;
   logic       button_in;
   logic       busy_in;
   logic       start_out;
   logic       loop_forever_out;
   logic       pressed_out;
   logic       pending_out;
   logic [1:0] state_out;

   int checks   = 0;
   int failures = 0;

   always #5 clock_in = ~clock_in;

   tvbg_button_conditioner #(
      .ACTIVE_LOW      (1'b1),
      .DEBOUNCE_CYCLES (D),
      .LONG_CYCLES     (L)
   ) dut (
      .clock_in         (clock_in),
      .reset_in         (reset_in),
      .button_in        (button_in),
      .busy_in          (busy_in),
      .start_out        (start_out),
      .loop_forever_out (loop_forever_out),
      .pressed_out      (pressed_out),
      .pending_out      (pending_out),
      .state_out        (state_out)
   );

   // behavioural model state
   logic       samp_q [$];   // normalised samples, oldest first
   int         run;          // consecutive samples disagreeing with accepted level
   logic       mp, mstart, mpend, mloop, req_d, islong;
   int         plen;
   logic [1:0] mstate;

   // observation of DUT events (measured, compared against literals)
   int   cyc = 0;
   int   start_cnt, rise_cyc, fall_cyc, loop_cyc, start_cyc;
   logic prev_pressed, prev_loop, pressed_seen;
   logic busy_v;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // One clock edge of the specified behaviour, from the inputs sampled there.
   task automatic model_step(input logic r, input logic b, input logic busy);
      logic seen, rise_e, fall_e, nreq, nstart;
      if (r) begin
         samp_q = '{1'b0, 1'b0};
         run = 0; mp = 1'b0; mstart = 1'b0; mpend = 1'b0; mloop = 1'b0;
         req_d = 1'b0; islong = 1'b0; plen = 0; mstate = 2'd0;
      end else begin
         // the level seen by the filter is the pin as it was two edges ago
         seen = samp_q.pop_front();
         samp_q.push_back(~b);
         rise_e = 1'b0; fall_e = 1'b0;
         if (seen != mp) begin
            run++;
            if (run == D + 1) begin
               mp = ~mp; run = 0; rise_e = mp; fall_e = ~mp;
            end
         end else begin
            run = 0;
         end
         // queue acts on the request produced one edge earlier
         nstart = 1'b0;
         if (mpend && !busy && !mstart) begin
            nstart = 1'b1; mpend = 1'b0;
         end else if (req_d && !mpend) begin
            if (busy || mstart) mpend = 1'b1; else nstart = 1'b1;
         end
         mstart = nstart;
         nreq = 1'b0;
`ifdef TVBG_BTN_LONGPRESS_EN
         if (rise_e) begin
            plen = 0; islong = 1'b0; mstate = 2'd1;
         end else if (fall_e) begin
            nreq = !islong; islong = 1'b0; mstate = 2'd0;
         end else if (mp && !islong) begin
            plen++;
            if (plen == L) begin
               islong = 1'b1; mloop = !mloop; mstate = 2'd2;
            end
         end
`else
         if (rise_e) begin
            nreq = 1'b1; mstate = 2'd1;
         end else if (fall_e) begin
            mstate = 2'd0;
         end
`endif
         req_d = nreq;
      end
   endtask

   task automatic tick(input logic r, input logic b, input logic busy);
      reset_in  = r;
      button_in = b;
      busy_in   = busy;
      @(posedge clock_in);
      model_step(r, b, busy);
      #1;
      chk("pressed_out", pressed_out, mp);
      chk("start_out", start_out, mstart);
      chk("pending_out", pending_out, mpend);
      chk("loop_forever_out", loop_forever_out, mloop);
      chk("state_out", state_out, mstate);
      if (pressed_out === 1'b1 && prev_pressed !== 1'b1) rise_cyc = cyc;
      if (pressed_out === 1'b0 && prev_pressed === 1'b1) fall_cyc = cyc;
      if (pressed_out === 1'b1) pressed_seen = 1'b1;
      if (loop_forever_out !== prev_loop) loop_cyc = cyc;
      if (start_out === 1'b1) begin
         start_cnt++;
         start_cyc = cyc;
      end
      prev_pressed = pressed_out;
      prev_loop    = loop_forever_out;
      cyc++;
   endtask

   task automatic hold(input logic b, input int n);
      for (int i = 0; i < n; i++) tick(1'b0, b, busy_v);
   endtask

   task automatic clear_obs();
      start_cnt = 0; rise_cyc = -1; fall_cyc = -1; loop_cyc = -1; start_cyc = -1;
      pressed_seen = 1'b0;
   endtask

   initial begin
      int e0, len, nseg;
      logic bv;
      prev_pressed = 1'b0; prev_loop = 1'b0; busy_v = 1'b0;
      clear_obs();

      // reset state
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      chk("reset_outputs", {27'd0, start_out, loop_forever_out, pressed_out, pending_out, (state_out != 2'd0)}, 32'd0);
      hold(1'b1, 5);

      // glitch of 3 cycles never gets through
      clear_obs();
      hold(1'b0, 3);
      hold(1'b1, 15);
      chk("glitch_pressed", pressed_seen, 1'b0);
      chk("glitch_start", start_cnt, 0);

      // short press
      clear_obs();
      e0 = cyc;
      hold(1'b0, 10);
      hold(1'b1, 20);
      chk("short_rise_latency", rise_cyc - e0, 6);
      chk("short_start_count", start_cnt, 1);
`ifdef TVBG_BTN_LONGPRESS_EN
      chk("short_start_after_fall", start_cyc - fall_cyc, 1);
`else
      chk("press_start_after_rise", start_cyc - rise_cyc, 1);
`endif
      chk("short_loop", loop_forever_out, 1'b0);

      // long press, twice
      clear_obs();
      hold(1'b0, 40);
      hold(1'b1, 20);
`ifdef TVBG_BTN_LONGPRESS_EN
      chk("long_loop_delay", loop_cyc - rise_cyc, L);
      chk("long_loop_on", loop_forever_out, 1'b1);
      chk("long_no_start", start_cnt, 0);
      clear_obs();
      hold(1'b0, 40);
      hold(1'b1, 20);
      chk("long_loop_off", loop_forever_out, 1'b0);
      chk("long2_no_start", start_cnt, 0);
`else
      chk("long_loop_tied", loop_forever_out, 1'b0);
      chk("long_start_count", start_cnt, 1);
      chk("long_no_start_on_release", start_cyc - rise_cyc, 1);
`endif

      // busy: queue one, drop the second, release on busy low
      clear_obs();
      busy_v = 1'b1;
      hold(1'b0, 10);
      hold(1'b1, 20);
      chk("busy_pending", pending_out, 1'b1);
      chk("busy_no_start", start_cnt, 0);
      hold(1'b0, 10);
      hold(1'b1, 20);
      chk("busy_second_pending", pending_out, 1'b1);
      chk("busy_second_no_start", start_cnt, 0);
      busy_v = 1'b0;
      hold(1'b1, 1);
      chk("busy_release_start", start_out, 1'b1);
      chk("busy_release_pending", pending_out, 1'b0);
      hold(1'b1, 6);
      chk("busy_single_start", start_cnt, 1);

      // reset in the middle of a hold with a queued start (and loop mode on)
      clear_obs();
      busy_v = 1'b1;
      hold(1'b0, 10);
      hold(1'b1, 20);
      hold(1'b0, 40);
      chk("pre_reset_pending", pending_out, 1'b1);
`ifdef TVBG_BTN_LONGPRESS_EN
      chk("pre_reset_loop", loop_forever_out, 1'b1);
`endif
      tick(1'b1, 1'b0, 1'b1);
      chk("reset_hold_outputs", {27'd0, start_out, loop_forever_out, pressed_out, pending_out, (state_out != 2'd0)}, 32'd0);
      busy_v = 1'b0;
      clear_obs();
      e0 = cyc;
      hold(1'b0, 10);
      chk("reset_repress_latency", rise_cyc - e0, 6);
      hold(1'b1, 20);
      chk("reset_repress_start", start_cnt, 1);

      // randomized segments checked against the model every cycle
      nseg = 200;
      for (int s = 0; s < nseg; s++) begin
         len    = $urandom_range(1, 45);
         bv     = 1'($urandom_range(0, 1));
         busy_v = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
         if ($urandom_range(0, 49) == 0) tick(1'b1, bv, busy_v);
         hold(bv, len);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
